// File: rtl/smbus_pkg.sv
// Shared SMBus definitions used by the mailbox target and the relay blocks.
//   smb_state_e   : byte-level target FSM states
//   SMB_RW_*      : value of the R/W bit that follows the 7-bit address
//   SMB_MAX_REGS  : largest mailbox the 4-bit register index can address
//   smb_ptr_inc   : mailbox pointer increment with power-of-two wrap
package smbus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_CMD       = 4'd3,
        ST_CMD_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_WAIT_STOP = 4'd9
    } smb_state_e;

    localparam logic SMB_RW_WRITE = 1'b0;
    localparam logic SMB_RW_READ  = 1'b1;

    localparam int SMB_MAX_REGS = 16;

    // The mailbox depth is a power of two, so wrap is a mask.
    function automatic logic [3:0] smb_ptr_inc(input logic [3:0] ptr,
                                               input logic [3:0] mask);
        return (ptr + 4'd1) & mask;
    endfunction

endpackage

// File: rtl/smbus_input_filter.sv
// Pad conditioner: 2-FF synchronizer followed by a glitch filter.
// The filtered level only changes after FILTER_CYCLES consecutive
// synchronized samples that differ from it; any shorter excursion is dropped.
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset (everything resets to 1)
//   ia_pad   : asynchronous pad level
//   o_level  : filtered level
module smbus_input_filter #(
    parameter int FILTER_CYCLES = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic ia_pad,
    output logic o_level
);

    localparam logic [3:0] CNT_LAST = 4'(FILTER_CYCLES - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level;
    logic [3:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= 4'd0;
        end else begin
            r_sync1 <= ia_pad;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= 4'd0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= 4'd0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/smbus_mailbox_target.sv
// SMBus target exposing a small byte mailbox to both the bus and local logic.
// Bus write: S addr+W A cmd A data A ... P  (cmd selects the start register)
// Bus read : S addr+R A data A ... data N P (starts at the current pointer)
// Combined format (write cmd, repeated START, read) is supported.
// Ports:
//   iClk, iRst_n        : system clock, asynchronous active-low reset
//   ia_scl, ia_sda      : asynchronous SMBus pad levels
//   o_sda_oe            : 1 pulls SDA low, 0 releases it (SCL is never driven)
//   i_local_wr/addr/wdata : local write port (one-cycle strobe)
//   o_local_rdata       : combinational read of register[i_local_addr]
//   o_smb_wr_pulse/addr : one-cycle pulse and index for each bus-written byte
//   o_busy              : addressed transaction in progress
//   o_dbg_state         : current FSM state
module smbus_mailbox_target
    import smbus_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR    = 7'h38,
    parameter int          FILTER_CYCLES = 3,
    parameter int          NUM_REGS      = 16
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       ia_scl,
    input  logic       ia_sda,
    output logic       o_sda_oe,
    input  logic       i_local_wr,
    input  logic [3:0] i_local_addr,
    input  logic [7:0] i_local_wdata,
    output logic [7:0] o_local_rdata,
    output logic       o_smb_wr_pulse,
    output logic [3:0] o_smb_wr_addr,
    output logic       o_busy,
    output smb_state_e o_dbg_state
);

    localparam logic [3:0] PTR_MASK   = 4'(NUM_REGS - 1);
    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    // ------------------------------------------------------------------
    // Pad conditioning and bus-condition detection
    // ------------------------------------------------------------------
    logic w_scl;
    logic w_sda;

    smbus_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_filter (
        .i_clk   (iClk),
        .i_rst_n (iRst_n),
        .ia_pad  (ia_scl),
        .o_level (w_scl)
    );

    smbus_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_filter (
        .i_clk   (iClk),
        .i_rst_n (iRst_n),
        .ia_pad  (ia_sda),
        .o_level (w_sda)
    );

    logic r_scl_d;
    logic r_sda_d;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    // SCL must be high on both samples so an SDA change that merely
    // coincides with an SCL edge is never taken for START/STOP.
    assign w_start = r_sda_d & ~w_sda & w_scl & r_scl_d;
    assign w_stop  = ~r_sda_d & w_sda & w_scl & r_scl_d;

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    smb_state_e r_state;
    logic [3:0] r_cnt;      // write states: SCL rises seen; RDATA: bits already shifted out
    logic [7:0] r_shift;    // received byte; bit 0 holds R/W while in ADDR_ACK
    logic [7:0] r_tx;       // read byte latched at its first drive edge
    logic [3:0] r_ptr;
    logic       r_sda_oe;
    logic       r_busy;
    logic       r_wr_pulse;
    logic [3:0] r_wr_addr;
    logic [7:0] r_regs [SMB_MAX_REGS];

    smb_state_e w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic [7:0] w_shift_nxt;
    logic [7:0] w_tx_nxt;
    logic [3:0] w_ptr_nxt;
    logic       w_oe_nxt;
    logic       w_busy_nxt;
    logic       w_smb_we;
    logic [7:0] w_smb_wdata;
    logic [7:0] w_rd_byte;

    assign w_rd_byte = r_regs[r_ptr];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_ptr_nxt   = r_ptr;
        w_oe_nxt    = r_sda_oe;
        w_busy_nxt  = r_busy;
        w_smb_we    = 1'b0;
        w_smb_wdata = {r_shift[6:0], w_sda};

        if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = 4'd0;
        end else if (w_start) begin
            w_state_nxt = ST_ADDR;
            w_oe_nxt    = 1'b0;
            w_cnt_nxt   = 4'd0;
        end else begin
            case (r_state)
                ST_ADDR, ST_CMD, ST_WDATA: begin
                    if (w_scl_rise && r_cnt != 4'd8) begin
                        w_shift_nxt = {r_shift[6:0], w_sda};
                        w_cnt_nxt   = r_cnt + 4'd1;
                        // Data byte is committed on its 8th rising edge.
                        if (r_state == ST_WDATA && r_cnt == 4'd7) begin
                            w_smb_we  = 1'b1;
                            w_ptr_nxt = smb_ptr_inc(r_ptr, PTR_MASK);
                        end
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        if (r_state == ST_ADDR) begin
                            if (r_shift[7:1] == SLAVE_ADDR) begin
                                w_state_nxt = ST_ADDR_ACK;
                                w_oe_nxt    = 1'b1;
                                w_busy_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = ST_WAIT_STOP;
                                w_busy_nxt  = 1'b0;
                            end
                        end else if (r_state == ST_CMD) begin
                            if (r_shift < NUM_REGS_B) begin
                                w_ptr_nxt   = r_shift[3:0];
                                w_state_nxt = ST_CMD_ACK;
                                w_oe_nxt    = 1'b1;
                            end else begin
                                w_state_nxt = ST_WAIT_STOP;
                            end
                        end else begin
                            w_state_nxt = ST_WDATA_ACK;
                            w_oe_nxt    = 1'b1;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_cnt_nxt = 4'd0;
                        if (r_shift[0] == SMB_RW_READ) begin
                            w_state_nxt = ST_RDATA;
                            w_tx_nxt    = w_rd_byte;
                            w_oe_nxt    = ~w_rd_byte[7];
                        end else begin
                            w_state_nxt = ST_CMD;
                            w_oe_nxt    = 1'b0;
                        end
                    end
                end

                ST_CMD_ACK, ST_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_state_nxt = ST_WDATA;
                        w_oe_nxt    = 1'b0;
                        w_cnt_nxt   = 4'd0;
                    end
                end

                ST_RDATA: begin
                    if (w_scl_fall) begin
                        if (r_cnt == 4'd7) begin
                            // Bit 0 has been on the bus: release for the master ACK.
                            w_state_nxt = ST_RDATA_ACK;
                            w_oe_nxt    = 1'b0;
                            w_cnt_nxt   = 4'd0;
                            w_ptr_nxt   = smb_ptr_inc(r_ptr, PTR_MASK);
                        end else begin
                            w_tx_nxt  = {r_tx[6:0], 1'b0};
                            w_oe_nxt  = ~r_tx[6];
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end
                end

                ST_RDATA_ACK: begin
                    if (w_scl_rise && w_sda) begin
                        w_state_nxt = ST_WAIT_STOP;
                    end else if (w_scl_fall) begin
                        w_state_nxt = ST_RDATA;
                        w_tx_nxt    = w_rd_byte;
                        w_oe_nxt    = ~w_rd_byte[7];
                        w_cnt_nxt   = 4'd0;
                    end
                end

                default: begin
                    // IDLE and WAIT_STOP only leave on START/STOP.
                end
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_shift    <= 8'h00;
            r_tx       <= 8'h00;
            r_ptr      <= 4'd0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_ptr      <= w_ptr_nxt;
            r_sda_oe   <= w_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_wr_pulse <= w_smb_we;
            if (w_smb_we) begin
                r_wr_addr <= r_ptr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mailbox storage: bus write has priority on an index collision.
    // Entries at or above NUM_REGS are never written and read as zero.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < SMB_MAX_REGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < SMB_MAX_REGS; i++) begin
                if (i < NUM_REGS) begin
                    if (w_smb_we && r_ptr == 4'(i)) begin
                        r_regs[i] <= w_smb_wdata;
                    end else if (i_local_wr && i_local_addr == 4'(i)) begin
                        r_regs[i] <= i_local_wdata;
                    end
                end
            end
        end
    end

    assign o_local_rdata  = r_regs[i_local_addr];
    assign o_sda_oe       = r_sda_oe;
    assign o_smb_wr_pulse = r_wr_pulse;
    assign o_smb_wr_addr  = r_wr_addr;
    assign o_busy         = r_busy;
    assign o_dbg_state    = r_state;

endmodule

// File: doc/smbus_mailbox_target.md
SMBUS_MAILBOX_TARGET -- requirements
Module: smbus_mailbox_target

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h38: 7-bit SMBus address this target answers.
REQ-002 Parameter FILTER_CYCLES, default 3: consecutive equal samples before SCL/SDA filtered level changes.
REQ-003 Parameter NUM_REGS, default 16: mailbox depth in bytes; power of two, max 16.
REQ-004 iClk  input  1  system clock, 50 MHz.
REQ-005 iRst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 ia_scl  input  1  SMBus SCL pad level, asynchronous.
REQ-007 ia_sda  input  1  SMBus SDA pad level, asynchronous.
REQ-008 o_sda_oe  output  1  1 = pull SDA low; 0 = release.
REQ-009 i_local_wr  input  1  local-side write strobe, one cycle.
REQ-010 i_local_addr  input  4  local read/write register index.
REQ-011 i_local_wdata  input  8  local write data.
REQ-012 o_local_rdata  output  8  register[i_local_addr], combinational read.
REQ-013 o_smb_wr_pulse  output  1  one-cycle pulse per byte written from SMBus.
REQ-014 o_smb_wr_addr  output  4  register index of the last SMBus write; valid with the pulse.
REQ-015 o_busy  output  1  high from addressed-START to STOP/abort.

Function
REQ-016 Both pads pass a 2-FF synchronizer, then a FILTER_CYCLES glitch filter; all decoding uses filtered levels.
REQ-017 START/repeated-START = filtered SDA falls while SCL high; STOP = SDA rises while SCL high; either is recognised in every state.
REQ-018 Data bits are sampled on filtered SCL rising edge, MSB first.
REQ-019 FSM states: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-020 IDLE->ADDR on START; ADDR collects 8 bits; address match -> ADDR_ACK, mismatch -> WAIT_STOP with SDA never driven.
REQ-021 ACK timing: o_sda_oe asserts on the SCL falling edge ending bit 8 and deasserts on the SCL falling edge ending bit 9.
REQ-022 ADDR_ACK with R/W=0 -> CMD; with R/W=1 -> RDATA using the current pointer.
REQ-023 CMD byte < NUM_REGS: pointer loads it, ACK, -> WDATA; CMD >= NUM_REGS: NACK (SDA released), -> WAIT_STOP.
REQ-024 WDATA: byte written to register[pointer] at bit-8 SCL rise; o_smb_wr_pulse high that cycle, o_smb_wr_addr = pointer; pointer increments modulo NUM_REGS; ACK; repeat until START/STOP.
REQ-025 Repeated START in WDATA before any data bit -> ADDR (write-then-read combined format).
REQ-026 RDATA: bit 7 of register[pointer] driven on the SCL falling edge after the ACK; o_sda_oe = ~bit; remaining bits on successive SCL falls; pointer increments after bit 0.
REQ-027 RDATA_ACK: master ACK (SDA low at SCL rise) -> RDATA with next byte; NACK -> WAIT_STOP with SDA released.
REQ-028 Pointer wraps NUM_REGS-1 -> 0 for both reads and writes.
REQ-029 Simultaneous local and SMBus write to the same register in one cycle: SMBus data wins; different registers: both take effect.
REQ-030 Read byte is latched into a shift register at the first drive edge; local writes during the byte do not alter bits already on the bus.
REQ-031 STOP anywhere -> IDLE, o_sda_oe = 0 within 1 cycle of detection; o_busy falls the same cycle.
REQ-032 No clock stretching: SCL is never driven.

Reset
REQ-033 Reset values: FSM IDLE, o_sda_oe 0, o_smb_wr_pulse 0, o_smb_wr_addr 0, o_busy 0, pointer 0, all registers 8'h00, synchronizers and filters 1.
REQ-034 Reset asserted mid-transaction releases SDA asynchronously; after release the block waits for a fresh START.

Structure
REQ-035 FSM state enum and SMBus R/W bit constants belong in the shared SMBus package used by the relay blocks.
REQ-036 Sync-plus-glitch-filter is one sub-module, smbus_input_filter, instantiated once per pad.

Verification
REQ-037 Write: S 0x70 A 0x05 A 0xA5 A P -> reg5=0xA5, one o_smb_wr_pulse with o_smb_wr_addr=5, ACK on all three bytes.
REQ-038 Combined read: local write reg3=0x3C; S 0x70 0x03 Sr 0x71, master NACK, P -> bus returns 0x3C, o_busy low after P.
REQ-039 Wrap: S 0x70 0x0F 0x11 0x22 P -> reg15=0x11, reg0=0x22.
REQ-040 Wrong address 0x72 and CMD 0x10 -> SDA never driven low / command byte NACKed, no register change.
REQ-041 1-cycle SDA glitch with SCL high (FILTER_CYCLES=3) -> no START/STOP detected.
REQ-042 iRst_n low during RDATA with o_sda_oe=1 -> o_sda_oe=0 immediately; next valid write transaction succeeds.
